// File: rtl/fifo_wr_packer_if.sv
// Narrow-stream / FIFO-write bundle for fifo_wr_packer.
// master = stimulus side (source plus FIFO status), slave = the packer.
interface fifo_wr_packer_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 128,
   parameter int CNT_W = 16
);
   logic             s_valid;
   logic             s_ready;
   logic [IN_W-1:0]  s_data;
   logic             s_last;
   logic             i_full;
   logic             i_alm_full;
   logic             o_wren;
   logic [OUT_W-1:0] o_wrdata;
   logic             o_busy;
   logic [CNT_W-1:0] o_word_cnt;

   modport master (
      output s_valid, s_data, s_last, i_full, i_alm_full,
      input  s_ready, o_wren, o_wrdata, o_busy, o_word_cnt
   );

   modport slave (
      input  s_valid, s_data, s_last, i_full, i_alm_full,
      output s_ready, o_wren, o_wrdata, o_busy, o_word_cnt
   );
endinterface

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow beats little-endian into one FIFO word; s_last flushes a zero-padded partial word.
// Optional macro FIFO_PACKER_AFULL_THROTTLE_EN also stalls writes on i_alm_full.
module fifo_wr_packer #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 128,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   fifo_wr_packer_if.slave   bus
);
   localparam int RATIO  = OUT_W / IN_W;
   localparam int LANE_W = $clog2(RATIO);
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);
   localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1'b1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);

   logic [OUT_W-1:0]  acc_r;
   logic [LANE_W-1:0] lane_r;
   logic [OUT_W-1:0]  hold_r;
   logic              hold_v_r;
   logic [CNT_W-1:0]  cnt_r;

   logic              stall_s;
   logic              wren_s;
   logic              ready_s;
   logic              accept_s;
   logic              complete_s;
   logic [OUT_W-1:0]  merged_s;

`ifdef FIFO_PACKER_AFULL_THROTTLE_EN
   assign stall_s = bus.i_full | bus.i_alm_full;
`else
   logic unused_alm_full_s;
   assign unused_alm_full_s = bus.i_alm_full;
   assign stall_s = bus.i_full;
`endif

   assign wren_s     = hold_v_r & ~stall_s;
   assign ready_s    = ~hold_v_r | wren_s;
   assign accept_s   = bus.s_valid & ready_s;
   assign complete_s = accept_s & ((lane_r == LANE_LAST) | bus.s_last);

   // Accumulator with the incoming beat in the current lane; lanes above it are zeroed
   always_comb begin
      merged_s = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (i < int'(lane_r)) begin
            merged_s[i*IN_W +: IN_W] = acc_r[i*IN_W +: IN_W];
         end else if (i == int'(lane_r)) begin
            merged_s[i*IN_W +: IN_W] = bus.s_data;
         end else begin
            merged_s[i*IN_W +: IN_W] = '0;
         end
      end
   end

   // Packing state, hold register and written-word counter
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r    <= '0;
         lane_r   <= '0;
         hold_r   <= '0;
         hold_v_r <= 1'b0;
         cnt_r    <= '0;
      end else begin
         if (complete_s) begin
            // A reload in the same cycle as a write keeps hold_v set: no bubble
            hold_r   <= merged_s;
            hold_v_r <= 1'b1;
            acc_r    <= '0;
            lane_r   <= '0;
         end else if (accept_s) begin
            acc_r    <= merged_s;
            lane_r   <= lane_r + LANE_ONE;
            hold_v_r <= hold_v_r & ~wren_s;
         end else begin
            hold_v_r <= hold_v_r & ~wren_s;
         end
         if (wren_s) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign bus.s_ready    = ready_s;
   assign bus.o_wren     = wren_s;
   assign bus.o_wrdata   = hold_r;
   assign bus.o_busy     = hold_v_r | (lane_r != '0);
   assign bus.o_word_cnt = cnt_r;
endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed self-checking bench for fifo_wr_packer; inputs change 1 time unit after posedge,
// outputs are checked in that same settled window.
module tb_fifo_wr_packer;
   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   fifo_wr_packer_if #(.IN_W(32), .OUT_W(128), .CNT_W(16)) bus ();

   fifo_wr_packer #(.IN_W(32), .OUT_W(128), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present one beat for exactly one clock edge
   task automatic send(input logic [31:0] data, input logic last);
      bus.s_valid = 1'b1;
      bus.s_data  = data;
      bus.s_last  = last;
      tick();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   initial begin
      int n_wr;
      int bad_gap;
      int not_ready;
      int last_wr;
      logic [127:0] last_word;

      n_chk = 0;
      n_err = 0;
      bus.s_valid    = 1'b0;
      bus.s_data     = 32'h0;
      bus.s_last     = 1'b0;
      bus.i_full     = 1'b0;
      bus.i_alm_full = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      chk1  ("rst_s_ready", bus.s_ready, 1'b1);
      chk1  ("rst_wren",    bus.o_wren, 1'b0);
      chk128("rst_wrdata",  bus.o_wrdata, 128'h0);
      chk1  ("rst_busy",    bus.o_busy, 1'b0);
      chk16 ("rst_cnt",     bus.o_word_cnt, 16'd0);

      // Full word
      send(32'h11111111, 1'b0);
      send(32'h22222222, 1'b0);
      chk1  ("full_busy_mid", bus.o_busy, 1'b1);
      chk1  ("full_nowr_mid", bus.o_wren, 1'b0);
      send(32'h33333333, 1'b0);
      send(32'h44444444, 1'b0);
      chk1  ("full_wren", bus.o_wren, 1'b1);
      chk128("full_data", bus.o_wrdata, 128'h44444444_33333333_22222222_11111111);
      tick();
      chk1  ("full_wren_once", bus.o_wren, 1'b0);
      chk16 ("full_cnt", bus.o_word_cnt, 16'd1);

      // Partial flush
      send(32'hAAAA0001, 1'b0);
      send(32'hAAAA0002, 1'b1);
      chk1  ("part_wren", bus.o_wren, 1'b1);
      chk128("part_data", bus.o_wrdata, 128'h00000000_00000000_AAAA0002_AAAA0001);
      tick();
      chk1  ("part_busy", bus.o_busy, 1'b0);
      chk16 ("part_cnt", bus.o_word_cnt, 16'd2);

      // Back-pressure
      bus.i_full = 1'b1;
      send(32'h55555551, 1'b0);
      send(32'h55555552, 1'b0);
      send(32'h55555553, 1'b0);
      send(32'h55555554, 1'b0);
      chk1  ("bp_wren_full", bus.o_wren, 1'b0);
      chk1  ("bp_ready_full", bus.s_ready, 1'b0);
      chk128("bp_hold", bus.o_wrdata, 128'h55555554_55555553_55555552_55555551);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h66666661;
      tick();
      tick();
      chk1  ("bp_wren_held", bus.o_wren, 1'b0);
      chk1  ("bp_ready_held", bus.s_ready, 1'b0);
      chk128("bp_hold_kept", bus.o_wrdata, 128'h55555554_55555553_55555552_55555551);
      chk16 ("bp_cnt_held", bus.o_word_cnt, 16'd2);
      bus.i_full = 1'b0;
      #1;
      chk1  ("bp_release_wren", bus.o_wren, 1'b1);
      chk1  ("bp_release_ready", bus.s_ready, 1'b1);
      tick();
      chk16 ("bp_cnt_after", bus.o_word_cnt, 16'd3);
      bus.s_data = 32'h66666662;
      tick();
      bus.s_data = 32'h66666663;
      tick();
      bus.s_valid = 1'b0;
      chk1  ("bp_busy_lane3", bus.o_busy, 1'b1);
      send(32'h66666664, 1'b0);
      chk1  ("bp_next_wren", bus.o_wren, 1'b1);
      chk128("bp_next_data", bus.o_wrdata, 128'h66666664_66666663_66666662_66666661);
      tick();
      chk16 ("bp_cnt_final", bus.o_word_cnt, 16'd4);

      // Back-to-back throughput: 64 beats, one per clock
      n_wr = 0; bad_gap = 0; not_ready = 0; last_wr = 0; last_word = 128'h0;
      for (int i = 0; i < 65; i++) begin
         if (i < 64) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'hC0000000 | 32'(i);
            if (bus.s_ready !== 1'b1) not_ready++;
         end else begin
            bus.s_valid = 1'b0;
         end
         if (bus.o_wren === 1'b1) begin
            n_wr++;
            if (i - last_wr != 4) bad_gap++;
            last_wr = i;
            last_word = bus.o_wrdata;
         end
         tick();
      end
      chk_int("b2b_writes", n_wr, 16);
      chk_int("b2b_bad_gaps", bad_gap, 0);
      chk_int("b2b_not_ready", not_ready, 0);
      chk128 ("b2b_last_word", last_word, 128'hC000003F_C000003E_C000003D_C000003C);
      chk16  ("b2b_cnt", bus.o_word_cnt, 16'd20);

      // Reset mid-burst
      send(32'hDEAD0001, 1'b0);
      send(32'hDEAD0002, 1'b0);
      send(32'hDEAD0003, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk1  ("rmb_wren", bus.o_wren, 1'b0);
      chk1  ("rmb_busy", bus.o_busy, 1'b0);
      chk16 ("rmb_cnt", bus.o_word_cnt, 16'd0);
      send(32'h77777771, 1'b0);
      send(32'h77777772, 1'b0);
      send(32'h77777773, 1'b0);
      send(32'h77777774, 1'b0);
      chk1  ("rmb_next_wren", bus.o_wren, 1'b1);
      chk128("rmb_next_data", bus.o_wrdata, 128'h77777774_77777773_77777772_77777771);
      tick();
      chk16 ("rmb_next_cnt", bus.o_word_cnt, 16'd1);

      // Almost-full: throttles only when the macro is defined
      bus.i_alm_full = 1'b1;
      send(32'h88888881, 1'b0);
      send(32'h88888882, 1'b1);
`ifdef FIFO_PACKER_AFULL_THROTTLE_EN
      chk1  ("afull_wren", bus.o_wren, 1'b0);
      chk1  ("afull_ready", bus.s_ready, 1'b0);
      bus.i_alm_full = 1'b0;
      #1;
`else
      chk1  ("afull_ignored_ready", bus.s_ready, 1'b1);
`endif
      chk1  ("afull_wren_open", bus.o_wren, 1'b1);
      chk128("afull_data", bus.o_wrdata, 128'h00000000_00000000_88888882_88888881);
      tick();
      bus.i_alm_full = 1'b0;
      chk16 ("afull_cnt", bus.o_word_cnt, 16'd2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
